// File: rtl/rs_bank_sequencer.sv
// rs_bank_sequencer: round-robin arbiter for two requesters driving a bank
// of RS flip-flops through a setup / enable-strobe / hold sequence.
module rs_bank_sequencer #(
  parameter int ADDR_W        = 2,
  parameter int ENABLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_a_valid,
  output logic                   req_a_ready,
  input  logic [ADDR_W-1:0]      req_a_addr,
  input  logic [1:0]             req_a_op,
  input  logic                   req_b_valid,
  output logic                   req_b_ready,
  input  logic [ADDR_W-1:0]      req_b_addr,
  input  logic [1:0]             req_b_op,
  output logic [2**ADDR_W-1:0]   ff_r,
  output logic [2**ADDR_W-1:0]   ff_s,
  output logic [2**ADDR_W-1:0]   ff_en,
  output logic                   busy,
  output logic                   err
);

  localparam int N_FF = 2**ADDR_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0]      EN_LAST = 4'(ENABLE_CYCLES - 1);
  localparam logic [N_FF-1:0] ONE     = N_FF'(1);

  logic [1:0]        state;
  logic              last_b;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        op_q;
  logic [3:0]        cnt;

  logic              idle;
  logic              grant_a;
  logic              grant_b;
  logic              acc;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_op;
  logic [N_FF-1:0]   sel;

  // Gating with rst_n keeps ready low for the whole reset window.
  assign idle    = rst_n && (state == S_IDLE);
  assign grant_a = idle && req_a_valid
                   && (!req_b_valid || last_b);
  assign grant_b = idle && req_b_valid
                   && (!req_a_valid || !last_b);

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  assign acc      = grant_a || grant_b;
  assign acc_addr = grant_a ? req_a_addr : req_b_addr;
  assign acc_op   = grant_a ? req_a_op : req_b_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      last_b <= 1'b1;
      addr_q <= '0;
      op_q   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      err <= acc && (acc_op == OP_ILL);
      if (acc) begin
        last_b <= grant_b;
      end
      unique case (state)
        S_IDLE: begin
          if (acc && (acc_op != OP_ILL)) begin
            state  <= S_SETUP;
            addr_q <= acc_addr;
            op_q   <= acc_op;
          end
        end
        S_SETUP: begin
          state <= S_STROBE;
          cnt   <= '0;
        end
        S_STROBE: begin
          if (cnt == EN_LAST) begin
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel  = ONE << addr_q;
  assign busy = (state != S_IDLE);

  always_comb begin
    ff_r  = '0;
    ff_s  = '0;
    ff_en = '0;
    if (busy) begin
      unique case (1'b1)
        (op_q == OP_SET): ff_s = sel;
        (op_q == OP_RST): ff_r = sel;
        default: ;
      endcase
      if (state == S_STROBE) begin
        ff_en = sel;
      end
    end
  end

endmodule

// File: tb/tb_rs_bank_sequencer.sv
// tb_rs_bank_sequencer: queue-driven requesters, trace scoreboard checked
// every cycle, plus a directed ENABLE_CYCLES=3 instance.
module tb_rs_bank_sequencer;

  localparam int EC = 1;

  typedef struct packed {
    logic [1:0] addr;
    logic [1:0] op;
  } cmd_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] s;
    logic [3:0] en;
    logic       busy;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_valid, b_valid, a_ready, b_ready;
  logic [1:0] a_addr, b_addr, a_op, b_op;
  logic [3:0] ff_r, ff_s, ff_en;
  logic       busy, err;

  logic       a3_valid, a3_ready, b3_ready;
  logic [1:0] a3_addr, a3_op;
  logic [3:0] r3, s3, en3;
  logic       busy3, err3;

  int n_chk = 0;
  int n_fail = 0;

  cmd_t qa[$];
  cmd_t qb[$];
  exp_t eq[$];
  logic last_b;
  logic rnd_gap = 1'b0;

  always #5 clk = ~clk;

  rs_bank_sequencer #(.ADDR_W(2), .ENABLE_CYCLES(EC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a_valid), .req_a_ready(a_ready),
    .req_a_addr(a_addr), .req_a_op(a_op),
    .req_b_valid(b_valid), .req_b_ready(b_ready),
    .req_b_addr(b_addr), .req_b_op(b_op),
    .ff_r(ff_r), .ff_s(ff_s), .ff_en(ff_en),
    .busy(busy), .err(err)
  );

  rs_bank_sequencer #(.ADDR_W(2), .ENABLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(a3_valid), .req_a_ready(a3_ready),
    .req_a_addr(a3_addr), .req_a_op(a3_op),
    .req_b_valid(1'b0), .req_b_ready(b3_ready),
    .req_b_addr(2'd0), .req_b_op(2'd0),
    .ff_r(r3), .ff_s(s3), .ff_en(en3),
    .busy(busy3), .err(err3)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requesters: hold each command until its handshake, then load the next.
  initial begin : drv
    logic acc_a, acc_b;
    cmd_t c;
    forever begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
      if (!a_valid && qa.size() > 0
          && (!rnd_gap || $urandom_range(0, 2) != 0)) begin
        c = qa.pop_front();
        a_valid = 1'b1; a_addr = c.addr; a_op = c.op;
      end
      if (!b_valid && qb.size() > 0
          && (!rnd_gap || $urandom_range(0, 2) != 0)) begin
        c = qb.pop_front();
        b_valid = 1'b1; b_addr = c.addr; b_op = c.op;
      end
    end
  end

  // Reference model + monitor: one expected record per cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    exp_t t;
    logic ga, gb;
    logic [1:0] ad, op;
    logic [3:0] oh;
    if (!rst_n) begin
      eq.delete();
      last_b = 1'b1;
    end else begin
      e = (eq.size() > 0) ? eq.pop_front() : '0;
      chk("ff_r", ff_r, e.r);
      chk("ff_s", ff_s, e.s);
      chk("ff_en", ff_en, e.en);
      chk("busy", busy, e.busy);
      chk("err", err, e.err);
      chk("rs_onehot", 32'($countones(ff_r | ff_s) <= 1), 1);
      chk("en_onehot", 32'($countones(ff_en) <= 1), 1);
      chk("rs_excl", ff_r & ff_s, 0);
      ga = !e.busy && a_valid && (!b_valid || last_b);
      gb = !e.busy && b_valid && (!a_valid || !last_b);
      chk("ready_a", a_ready, ga);
      chk("ready_b", b_ready, gb);
      if (ga || gb) begin
        last_b = gb;
        ad = ga ? a_addr : b_addr;
        op = ga ? a_op : b_op;
        oh = 4'b0001 << ad;
        if (op == 2'b11) begin
          t = '0;
          t.err = 1'b1;
          eq.push_back(t);
        end else begin
          t = '0;
          t.busy = 1'b1;
          t.r = (op == 2'b10) ? oh : 4'b0;
          t.s = (op == 2'b01) ? oh : 4'b0;
          eq.push_back(t);
          t.en = oh;
          for (int i = 0; i < EC; i++) eq.push_back(t);
          t.en = 4'b0;
          eq.push_back(t);
        end
      end
    end
  end

  task automatic wait_idle(int budget);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || a_valid || b_valid
            || busy || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int en_seen;
    logic got;
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 2'd0; b_addr = 2'd0; a_op = 2'b01; b_op = 2'b01;
    a3_valid = 1'b0; a3_addr = 2'd0; a3_op = 2'd0;
    #3;
    chk("rst_ready_a", a_ready, 0);
    chk("rst_ready_b", b_ready, 0);
    chk("rst_outs", {ff_r, ff_s, ff_en, busy, err}, 0);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    #10;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Tie after reset, both held: A, B, A, B.
    qa.push_back('{2'd1, 2'b01}); qa.push_back('{2'd3, 2'b10});
    qb.push_back('{2'd0, 2'b10}); qb.push_back('{2'd2, 2'b01});
    wait_idle(200);

    qa.push_back('{2'd2, 2'b01});
    wait_idle(50);

    // Illegal from B, then a tie must go to A.
    qb.push_back('{2'd1, 2'b11});
    wait_idle(50);
    qa.push_back('{2'd0, 2'b01});
    qb.push_back('{2'd3, 2'b10});
    wait_idle(100);

    qa.push_back('{2'd3, 2'b00});
    wait_idle(50);

    rnd_gap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      qa.push_back('{2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
      qb.push_back('{2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
    end
    wait_idle(3000);
    rnd_gap = 1'b0;

    // Reset between edges during STROBE.
    qa.push_back('{2'd1, 2'b01});
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (ff_en != 4'b0);
    end
    chk("strobe_reached", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {ff_r, ff_s, ff_en, busy, err}, 0);
    chk("midrst_ready", {a_ready, b_ready}, 0);
    @(negedge clk);
    chk("midrst_hold", {ff_r, ff_s, ff_en, busy}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    en_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ff_en != 4'b0) en_seen++;
    end
    chk("no_en_after_rst", en_seen, 0);
    qb.push_back('{2'd2, 2'b10});
    qa.push_back('{2'd0, 2'b01});
    wait_idle(100);

    // ENABLE_CYCLES=3: reset op on flip-flop 0.
    @(posedge clk);
    #1;
    a3_valid = 1'b1; a3_addr = 2'd0; a3_op = 2'b10;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = a3_ready;
    end
    chk("ec3_ready", got, 1);
    @(posedge clk);
    #1 a3_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("ec3_ff_r", r3, (i <= 5) ? 4'b0001 : 4'b0000);
      chk("ec3_ff_s", s3, 4'b0000);
      chk("ec3_ff_en", en3, (i >= 2 && i <= 4) ? 4'b0001 : 4'b0000);
      chk("ec3_busy", busy3, (i <= 5) ? 1 : 0);
      chk("ec3_err", err3, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
